// File: rtl/main_mem_responder_if.sv
// Request/response bus between a memory requester and main_mem_responder.
// The requester drives strobe, direction, address and write data; the
// responder returns read data, its valid flag and the outstanding-read count.
interface main_mem_responder_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 16
);
    logic              enable;
    logic              wr;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data_in;
    logic [DWIDTH-1:0] data_out;
    logic              data_valid;
    logic [3:0]        in_flight;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid, in_flight
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid, in_flight
    );
endinterface

// File: rtl/main_mem_responder.sv
// Fixed-latency main memory model.
// Writes land in storage at the accepting edge; reads capture the addressed
// word at the accepting edge and carry it down a LATENCY-deep pipeline, so a
// later write to the same word never disturbs a read already issued.
// Storage has no reset; only the pipeline valid bits and the outstanding-read
// counter are cleared, asynchronously, by rst.
module main_mem_responder #(
    parameter int DWIDTH  = 16,
    parameter int AWIDTH  = 16,
    parameter int LATENCY = 4,
    parameter int MEM_AW  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    main_mem_responder_if.slave  bus
);

    localparam int DEPTH = 1 << MEM_AW;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [MEM_AW-1:0] word_idx;
    logic              rd_accept;
    logic              wr_accept;
    logic              rd_retire;
    logic [LATENCY-1:0] stage_valid;
    logic [DWIDTH-1:0]  stage_data [LATENCY];
    logic [3:0]         in_flight_cnt;

    // Byte address to word index; bit 0 and the high bits alias away.
    assign word_idx  = bus.addr[MEM_AW:1];

    // Requests seen while rst is high are dropped, writes included.
    assign rd_accept = bus.enable & ~bus.wr & ~rst;
    assign wr_accept = bus.enable &  bus.wr & ~rst;
    assign rd_retire = stage_valid[LATENCY-1];

    // Storage write port; contents survive reset untouched.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[word_idx] <= bus.data_in;
        end
    end

    // Read pipeline valid bits, flushed immediately by reset so in-flight reads never return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid <= '0;
        end else begin
            stage_valid[0] <= rd_accept;
            for (int i = 1; i < LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
            end
        end
    end

    // Read pipeline data; the word is sampled at issue, which gives old-data semantics on a following write.
    always_ff @(posedge clk) begin
        stage_data[0] <= mem[word_idx];
        for (int i = 1; i < LATENCY; i++) begin
            stage_data[i] <= stage_data[i-1];
        end
    end

    // Outstanding-read counter: up on accept, down on return, held when both happen together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight_cnt <= 4'd0;
        end else begin
            case ({rd_accept, rd_retire})
                2'b10:   in_flight_cnt <= in_flight_cnt + 4'd1;
                2'b01:   in_flight_cnt <= in_flight_cnt - 4'd1;
                default: in_flight_cnt <= in_flight_cnt;
            endcase
        end
    end

    assign bus.data_valid = stage_valid[LATENCY-1];
    assign bus.data_out   = stage_valid[LATENCY-1] ? stage_data[LATENCY-1] : '0;
    assign bus.in_flight  = in_flight_cnt;

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed self-checking bench for main_mem_responder with default
// parameters (16-bit data/address, LATENCY=4, MEM_AW=10).
// Outputs are sampled 1 time unit after each rising edge.
module tb_main_mem_responder;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    main_mem_responder_if #(.DWIDTH(16), .AWIDTH(16)) bus ();

    main_mem_responder #(
        .DWIDTH (16),
        .AWIDTH (16),
        .LATENCY(4),
        .MEM_AW (10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic expectBus(input string tag, input logic dv, input logic [15:0] dout, input logic [3:0] inflt);
        checkOutput({tag, "_valid"},    32'(bus.data_valid), 32'(dv));
        checkOutput({tag, "_data"},     32'(bus.data_out),   32'(dout));
        checkOutput({tag, "_inflight"}, 32'(bus.in_flight),  32'(inflt));
    endtask

    task automatic applyStimulus(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        bus.enable  = en;
        bus.wr      = w;
        bus.addr    = a;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    // Single read, then watch it come back on the 4th sample after issue.
    task automatic readCheck(input string tag, input logic [15:0] a, input logic [15:0] exp_word);
        applyStimulus(1'b1, 1'b0, a, 16'h0000);
        expectBus({tag, "_c0"}, 1'b0, 16'h0000, 4'd1);
        idle();
        expectBus({tag, "_c1"}, 1'b0, 16'h0000, 4'd1);
        idle();
        expectBus({tag, "_c2"}, 1'b0, 16'h0000, 4'd1);
        idle();
        expectBus({tag, "_c3"}, 1'b1, exp_word, 4'd1);
        idle();
        expectBus({tag, "_c4"}, 1'b0, 16'h0000, 4'd0);
    endtask

    initial begin
        logic       exp_dv;
        logic [15:0] exp_data;
        int         accepted;
        int         returned;

        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus.enable   = 1'b0;
        bus.wr       = 1'b0;
        bus.addr     = '0;
        bus.data_in  = '0;

        // Reset state before and across clock edges
        #1;
        expectBus("reset_pre_clk", 1'b0, 16'h0000, 4'd0);
        idle();
        idle();
        expectBus("reset_held", 1'b0, 16'h0000, 4'd0);
        #3 rst = 1'b0;
        #1;

        // Write then read: valid on the 4th sample, in_flight 1,1,1,1,0
        applyStimulus(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        expectBus("wr_beef", 1'b0, 16'h0000, 4'd0);
        readCheck("rd_beef", 16'h0010, 16'hBEEF);

        // Six back-to-back reads of 0x0001..0x0006
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 16'(16'h0100 + 2*i), 16'(i + 1));
        end
        for (int k = 0; k < 10; k++) begin
            if (k < 6) applyStimulus(1'b1, 1'b0, 16'(16'h0100 + 2*k), 16'h0000);
            else       idle();
            accepted = (k + 1 < 6) ? k + 1 : 6;
            returned = (k - 3 < 0) ? 0 : ((k - 3 > 6) ? 6 : k - 3);
            exp_dv   = (k >= 3 && k <= 8);
            exp_data = exp_dv ? 16'(k - 2) : 16'h0000;
            expectBus($sformatf("burst_k%0d", k), exp_dv, exp_data, 4'(accepted - returned));
        end

        // Read in flight keeps old data when the same word is then written
        applyStimulus(1'b1, 1'b1, 16'h0020, 16'h1111);
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000);
        expectBus("raw_c0", 1'b0, 16'h0000, 4'd1);
        applyStimulus(1'b1, 1'b1, 16'h0020, 16'h2222);
        expectBus("raw_c1", 1'b0, 16'h0000, 4'd1);
        idle();
        expectBus("raw_c2", 1'b0, 16'h0000, 4'd1);
        idle();
        expectBus("raw_c3", 1'b1, 16'h1111, 4'd1);
        idle();
        expectBus("raw_c4", 1'b0, 16'h0000, 4'd0);
        readCheck("raw_new", 16'h0020, 16'h2222);

        // Aliasing: 0x0803 maps to the same word as 0x0002
        applyStimulus(1'b1, 1'b1, 16'h0002, 16'hA5A5);
        readCheck("alias", 16'h0803, 16'hA5A5);

        // Reset mid-operation with reads outstanding
        applyStimulus(1'b1, 1'b1, 16'h0040, 16'h3333);
        applyStimulus(1'b1, 1'b1, 16'h0042, 16'h4444);
        applyStimulus(1'b1, 1'b1, 16'h0044, 16'h5555);
        applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0042, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0044, 16'h0000);
        expectBus("rstmid_issue", 1'b0, 16'h0000, 4'd3);
        idle();
        expectBus("rstmid_ret", 1'b1, 16'h3333, 4'd3);
        #3 rst = 1'b1;
        #1;
        expectBus("rstmid_async", 1'b0, 16'h0000, 4'd0);
        applyStimulus(1'b1, 1'b1, 16'h0040, 16'hDEAD);
        expectBus("rstmid_wr_ign", 1'b0, 16'h0000, 4'd0);
        idle();
        expectBus("rstmid_held", 1'b0, 16'h0000, 4'd0);
        #3 rst = 1'b0;
        #1;
        readCheck("post_rst_a", 16'h0040, 16'h3333);

        // Write with enable low is ignored
        applyStimulus(1'b0, 1'b1, 16'h0042, 16'hBAD0);
        expectBus("en0_wr", 1'b0, 16'h0000, 4'd0);
        readCheck("en0_rb", 16'h0042, 16'h4444);
        readCheck("post_rst_b", 16'h0044, 16'h5555);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/main_mem_responder.md
MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, data word width.
REQ-002 SHALL have parameter AWIDTH, default 16, byte-address width.
REQ-003 SHALL have parameter LATENCY, default 4, read latency in cycles; legal range 1..8.
REQ-004 SHALL have parameter MEM_AW, default 10, log2 of storage depth in words; legal range 1..AWIDTH-1.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port enable, input, 1, request strobe, one request per asserted cycle.
REQ-008 SHALL have port wr, input, 1; with enable: 1 = write, 0 = read.
REQ-009 SHALL have port addr, input, AWIDTH, byte address of the request.
REQ-010 SHALL have port data_in, input, DWIDTH, write data.
REQ-011 SHALL have port data_out, output, DWIDTH, read return data.
REQ-012 SHALL have port data_valid, output, 1, data_out holds a completed read this cycle.
REQ-013 SHALL have port in_flight, output, 4, count of accepted reads not yet returned.

Function
REQ-014 SHALL accept a request on every cycle with enable=1; there is no backpressure.
REQ-015 SHALL select the word as addr[MEM_AW:1]; addr[0] and addr[AWIDTH-1:MEM_AW+1] are ignored, so aliased addresses hit the same word.
REQ-016 SHALL, on a write (enable=1, wr=1), update the addressed word at that clock edge, generating no data_valid and leaving in_flight unchanged.
REQ-017 SHALL, on a read (enable=1, wr=0), capture the addressed word at the accepting edge and push it into a LATENCY-stage pipeline.
REQ-018 SHALL assert data_valid exactly LATENCY cycles after the accepting edge, for one cycle per read, with data_out = captured word.
REQ-019 SHALL return back-to-back reads in issue order, one per cycle, with no bubbles.
REQ-020 SHALL return old data from a read in flight when a later write targets the same word (data captured at issue).
REQ-021 SHALL drive data_out = 0 whenever data_valid = 0.
REQ-022 SHALL maintain in_flight = number of valid pipeline stages, computed as +1 on read accept, -1 on return, unchanged when both occur in the same cycle; maximum LATENCY, never wraps.
REQ-023 SHALL not initialise storage contents, and SHALL leave them unchanged when rst asserts.
REQ-024 SHALL, when LATENCY=1, return data the cycle after the accepting edge with in_flight toggling 0/1.

Reset
REQ-025 SHALL, while rst=1, clear all pipeline valid bits and force data_valid=0, data_out=0, in_flight=0 immediately, without waiting for clk.
REQ-026 SHALL discard reads in flight when rst asserts mid-operation; they never return.
REQ-027 SHALL ignore requests presented while rst=1, including writes, which leave storage unchanged.
REQ-028 SHALL accept a request on the first rising edge after rst deasserts.

Verification
REQ-029 Bench SHALL cover: write 0xBEEF @0x0010, next cycle read @0x0010 -> data_valid exactly 4 cycles after the read edge, data_out=0xBEEF, in_flight 1,1,1,1,0.
REQ-030 Bench SHALL cover: 6 consecutive reads of words holding 0x0001..0x0006 -> 6 consecutive valid cycles in order, in_flight peaks at 4, data_out=0 on all other cycles.
REQ-031 Bench SHALL cover: read @0x0020 (holding 0x1111), next cycle write 0x2222 @0x0020 -> read returns 0x1111; a subsequent read returns 0x2222.
REQ-032 Bench SHALL cover: aliasing, write 0xA5A5 @0x0002, read @0x0803 (MEM_AW=10) -> returns 0xA5A5.
REQ-033 Bench SHALL cover: 3 reads issued, rst pulsed mid-cycle 2 cycles later -> data_valid, data_out and in_flight go to 0 asynchronously, no stale returns, and storage contents are preserved on a read after reset.
REQ-034 Bench SHALL cover: a write with enable=0 or with rst=1 -> storage unchanged on readback.
